// File: rtl/smc_access_seq_lite23_if.sv
// Request/handshake bundle between the AHB-side front end and the SMC
// access sequencer. The master drives the request, the slave (sequencer)
// returns the per-access handshake and state signals.
interface smc_access_seq_lite23_if #(
   parameter int WS_W  = 4,
   parameter int FLT_W = 2
);
   logic             new_access23;
   logic [1:0]       bus_size23;
   logic [1:0]       xfer_size23;
   logic [WS_W-1:0]  r_ws23;
   logic [FLT_W-1:0] r_float23;
   logic             valid_access23;
   logic [1:0]       v_bus_size23;
   logic [1:0]       v_xfer_size23;
   logic [1:0]       r_num_access23;
   logic             smc_done23;
   logic [4:0]       smc_nextstate23;
   logic             smc_busy23;
   logic             xfer_done23;

   modport master (
      output new_access23, bus_size23, xfer_size23, r_ws23, r_float23,
      input  valid_access23, v_bus_size23, v_xfer_size23, r_num_access23,
             smc_done23, smc_nextstate23, smc_busy23, xfer_done23
   );

   modport slave (
      input  new_access23, bus_size23, xfer_size23, r_ws23, r_float23,
      output valid_access23, v_bus_size23, v_xfer_size23, r_num_access23,
             smc_done23, smc_nextstate23, smc_busy23, xfer_done23
   );
endinterface

// File: rtl/smc_access_seq_lite23.sv
// SMC access sequencer: splits one transfer into 1/2/4 external accesses,
// each stretched by programmable wait states, then an optional bus
// turnaround (FLOAT) period before the next request can be taken.
module smc_access_seq_lite23 #(
   parameter int WS_W  = 4,
   parameter int FLT_W = 2
) (
   input logic                sys_clk23,
   input logic                sys_reset23,
   smc_access_seq_lite23_if.slave bus
);

   // One-hot encoding is shared with the address/CS/BE block; 5'b00010 unused.
   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_RW    = 5'b00100,
      ST_STORE = 5'b01000,
      ST_FLOAT = 5'b10000
   } state_t;

   state_t           r_state, w_next;
   logic [1:0]       r_num, r_bus, r_xfer, w_num_load;
   logic [WS_W-1:0]  r_wcnt, r_ws;
   logic [FLT_W-1:0] r_fcnt, r_flt;
   logic             r_busy, r_xdone;
   logic             w_valid, w_done;

   // Reset masks the combinational handshakes so nothing is accepted or
   // completed while the block is being cleared.
   assign w_valid = bus.new_access23 & (r_state == ST_IDLE) & ~sys_reset23;
   assign w_done  = (r_state == ST_RW) & (r_wcnt == '0) & ~sys_reset23;

   // Number of accesses minus one, from the live request sizes.
   always_comb begin
      w_num_load = 2'd0;
      if (bus.xfer_size23 == 2'b10 && bus.bus_size23 == 2'b00)
         w_num_load = 2'd3;
      else if (bus.xfer_size23 == 2'b10 && bus.bus_size23 == 2'b01)
         w_num_load = 2'd1;
      else if (bus.xfer_size23 == 2'b01 && bus.bus_size23 == 2'b00)
         w_num_load = 2'd1;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      if (sys_reset23) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_valid) w_next = ST_RW;
            ST_RW:    if (w_done && r_num == 2'd0) w_next = ST_STORE;
            ST_STORE: w_next = (r_flt != '0) ? ST_FLOAT : ST_IDLE;
            ST_FLOAT: if (r_fcnt == '0) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
         endcase
      end
   end

   // State register; busy and done flags are registered off the decode.
   always_ff @(posedge sys_clk23) begin
      if (sys_reset23) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_xdone <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != ST_IDLE);
         r_xdone <= (r_state == ST_STORE);
      end
   end

   // Request capture and access/wait/turnaround counters. Captured copies
   // isolate the in-flight transfer from later changes on the inputs.
   always_ff @(posedge sys_clk23) begin
      if (sys_reset23) begin
         r_num  <= 2'd0;
         r_bus  <= 2'd0;
         r_xfer <= 2'd0;
         r_ws   <= '0;
         r_flt  <= '0;
         r_wcnt <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_valid) begin
            r_bus  <= bus.bus_size23;
            r_xfer <= bus.xfer_size23;
            r_ws   <= bus.r_ws23;
            r_flt  <= bus.r_float23;
            r_num  <= w_num_load;
            r_wcnt <= bus.r_ws23;
         end else if (r_state == ST_RW) begin
            if (r_wcnt != '0) begin
               r_wcnt <= r_wcnt - 1'b1;
            end else if (r_num != 2'd0) begin
               r_num  <= r_num - 1'b1;
               r_wcnt <= r_ws;
            end
         end
         if (r_state == ST_STORE && r_flt != '0)
            r_fcnt <= r_flt - 1'b1;
         else if (r_state == ST_FLOAT && r_fcnt != '0)
            r_fcnt <= r_fcnt - 1'b1;
      end
   end

   assign bus.valid_access23  = w_valid;
   assign bus.smc_done23      = w_done;
   assign bus.smc_nextstate23 = w_next;
   assign bus.v_bus_size23    = w_valid ? bus.bus_size23  : r_bus;
   assign bus.v_xfer_size23   = w_valid ? bus.xfer_size23 : r_xfer;
   assign bus.r_num_access23  = r_num;
   assign bus.smc_busy23      = r_busy;
   assign bus.xfer_done23     = r_xdone;

endmodule

// File: tb/tb_smc_access_seq_lite23.sv
// Directed bench for the SMC access sequencer; expected values are
// hand-derived cycle by cycle from the acceptance cycle (cycle 0).
module tb_smc_access_seq_lite23;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   smc_access_seq_lite23_if #(.WS_W(4), .FLT_W(2)) ifc ();

   smc_access_seq_lite23 #(.WS_W(4), .FLT_W(2)) dut (
      .sys_clk23   (clk),
      .sys_reset23 (rst),
      .bus         (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] bs, input logic [1:0] xs,
                      input logic [3:0] ws, input logic [1:0] fl);
      ifc.new_access23 = 1'b1;
      ifc.bus_size23   = bs;
      ifc.xfer_size23  = xs;
      ifc.r_ws23       = ws;
      ifc.r_float23    = fl;
   endtask

   initial begin
      logic [1:0] v_xs [2];
      logic [1:0] v_bs [2];
      ifc.new_access23 = 1'b1;
      ifc.bus_size23   = 2'b00;
      ifc.xfer_size23  = 2'b00;
      ifc.r_ws23       = 4'd0;
      ifc.r_float23    = 2'd0;

      // Reset held with a request pending: nothing may be accepted.
      step; step;
      @(negedge clk);
      chk("rst_valid", ifc.valid_access23, 0);
      chk("rst_next",  ifc.smc_nextstate23, 5'b00001);
      chk("rst_done",  ifc.smc_done23, 0);
      step;
      rst = 1'b0;
      ifc.new_access23 = 1'b0;
      @(negedge clk);
      chk("idle_next", ifc.smc_nextstate23, 5'b00001);
      chk("idle_busy", ifc.smc_busy23, 0);
      chk("idle_xd",   ifc.xfer_done23, 0);
      chk("idle_num",  ifc.r_num_access23, 0);
      chk("idle_vbus", ifc.v_bus_size23, 0);
      chk("idle_done", ifc.smc_done23, 0);

      // xfer 32 / bus 8, ws 1: four accesses of 2 cycles each.
      step;
      req(2'b00, 2'b10, 4'd1, 2'd0);
      @(negedge clk);
      chk("t1_valid", ifc.valid_access23, 1);
      chk("t1_next",  ifc.smc_nextstate23, 5'b00100);
      chk("t1_vxfer", ifc.v_xfer_size23, 2'b10);
      for (int c = 1; c <= 10; c++) begin
         step;
         if (c == 1) ifc.new_access23 = 1'b0;
         @(negedge clk);
         chk($sformatf("t1_done_c%0d", c), ifc.smc_done23,
             (c == 2 || c == 4 || c == 6 || c == 8));
         if (c == 2 || c == 4 || c == 6 || c == 8)
            chk($sformatf("t1_num_c%0d", c), ifc.r_num_access23, (8 - c) / 2);
         chk($sformatf("t1_xd_c%0d", c), ifc.xfer_done23, (c == 10));
         chk($sformatf("t1_busy_c%0d", c), ifc.smc_busy23, (c <= 9));
      end
      chk("t1_idle", ifc.smc_nextstate23, 5'b00001);

      // xfer 16 / bus 16, ws 0, float 2, request held high throughout.
      step;
      req(2'b01, 2'b01, 4'd0, 2'd2);
      @(negedge clk);
      chk("t2_valid_c0", ifc.valid_access23, 1);
      for (int c = 1; c <= 5; c++) begin
         step;
         @(negedge clk);
         chk($sformatf("t2_valid_c%0d", c), ifc.valid_access23, (c == 5));
         if (c == 1) begin
            chk("t2_done", ifc.smc_done23, 1);
            chk("t2_num",  ifc.r_num_access23, 0);
         end
         if (c == 2) chk("t2_next_float", ifc.smc_nextstate23, 5'b10000);
         if (c == 3) chk("t2_xd", ifc.xfer_done23, 1);
         if (c == 4) chk("t2_busy_float", ifc.smc_busy23, 1);
      end
      // Let the second (accepted) transfer drain: RW, STORE, 2x FLOAT.
      for (int c = 6; c <= 10; c++) begin
         step;
         if (c == 6) ifc.new_access23 = 1'b0;
         @(negedge clk);
         if (c == 9)  chk("t2b_busy9", ifc.smc_busy23, 1);
         if (c == 10) chk("t2b_busy10", ifc.smc_busy23, 0);
      end

      // xfer 32 / bus 16, ws 3; inputs disturbed mid-transfer.
      step;
      req(2'b01, 2'b10, 4'd3, 2'd0);
      @(negedge clk);
      chk("t3_valid", ifc.valid_access23, 1);
      for (int c = 1; c <= 10; c++) begin
         step;
         if (c == 1) ifc.new_access23 = 1'b0;
         if (c == 2) begin
            ifc.r_ws23     = 4'd0;
            ifc.bus_size23 = 2'b00;
         end
         @(negedge clk);
         chk($sformatf("t3_done_c%0d", c), ifc.smc_done23, (c == 4 || c == 8));
         if (c == 4) chk("t3_num4", ifc.r_num_access23, 1);
         if (c == 8) chk("t3_num8", ifc.r_num_access23, 0);
         chk($sformatf("t3_vbus_c%0d", c), ifc.v_bus_size23, 2'b01);
         chk($sformatf("t3_xd_c%0d", c), ifc.xfer_done23, (c == 10));
      end

      // Single-access cases: xfer < bus, and reserved xfer encoding.
      v_xs[0] = 2'b00; v_bs[0] = 2'b10;
      v_xs[1] = 2'b11; v_bs[1] = 2'b00;
      for (int v = 0; v < 2; v++) begin
         step;
         req(v_bs[v], v_xs[v], 4'd0, 2'd0);
         @(negedge clk);
         chk($sformatf("t4_valid_%0d", v), ifc.valid_access23, 1);
         step;
         ifc.new_access23 = 1'b0;
         @(negedge clk);
         chk($sformatf("t4_done_%0d", v), ifc.smc_done23, 1);
         chk($sformatf("t4_num_%0d", v), ifc.r_num_access23, 0);
         step;
         @(negedge clk);
         chk($sformatf("t4_next_%0d", v), ifc.smc_nextstate23, 5'b00001);
         step;
         @(negedge clk);
         chk($sformatf("t4_xd_%0d", v), ifc.xfer_done23, 1);
      end

      // Reset in the second access of a 4-access transfer.
      step;
      req(2'b00, 2'b10, 4'd1, 2'd0);
      for (int c = 1; c <= 4; c++) begin
         step;
         if (c == 1) ifc.new_access23 = 1'b0;
         if (c == 4) rst = 1'b1;
      end
      @(negedge clk);
      chk("t5_rst_done", ifc.smc_done23, 0);
      chk("t5_rst_next", ifc.smc_nextstate23, 5'b00001);
      step;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_busy", ifc.smc_busy23, 0);
      chk("t5_num",  ifc.r_num_access23, 0);
      chk("t5_next", ifc.smc_nextstate23, 5'b00001);
      for (int c = 6; c <= 8; c++) begin
         step;
         @(negedge clk);
         chk($sformatf("t5_noxd_c%0d", c), ifc.xfer_done23, 0);
      end
      // Follow-up request: xfer 16 / bus 8, ws 0 -> two accesses.
      step;
      req(2'b00, 2'b01, 4'd0, 2'd0);
      @(negedge clk);
      chk("t5b_valid", ifc.valid_access23, 1);
      for (int c = 1; c <= 4; c++) begin
         step;
         if (c == 1) ifc.new_access23 = 1'b0;
         @(negedge clk);
         chk($sformatf("t5b_done_c%0d", c), ifc.smc_done23, (c == 1 || c == 2));
         if (c == 1) chk("t5b_num1", ifc.r_num_access23, 1);
         if (c == 2) chk("t5b_num2", ifc.r_num_access23, 0);
         chk($sformatf("t5b_xd_c%0d", c), ifc.xfer_done23, (c == 4));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
